fifo_stat: RTL

FIFO_STAT -- requirements
Module: fifo_stat

---
 rtl/fifo_stat.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fifo_stat.sv
// Synchronous show-ahead FIFO with registered level flags, a high-watermark
// of the fill level and sticky overflow/underflow indicators.
module fifo_stat #(
   parameter int D_WIDTH  = 8,
   parameter int A_WIDTH  = 4,
   parameter int AF_LEVEL = 2**A_WIDTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr,
   input  logic               rd,
   input  logic [D_WIDTH-1:0] w_data,
   input  logic               clr_err,
   output logic [D_WIDTH-1:0] r_data,
   output logic               empty,
   output logic               full,
   output logic               almost_empty,
   output logic               almost_full,
   output logic [A_WIDTH:0]   count,
   output logic [A_WIDTH:0]   max_count,
   output logic               overflow,
   output logic               underflow
);

   localparam int               DEPTH   = 2**A_WIDTH;
   localparam logic [A_WIDTH:0] DEPTH_C = DEPTH[A_WIDTH:0];
   localparam logic [A_WIDTH:0] AF_C    = AF_LEVEL[A_WIDTH:0];
   localparam logic [A_WIDTH:0] AE_C    = AE_LEVEL[A_WIDTH:0];

   logic [D_WIDTH-1:0] mem_q [DEPTH];

   logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [A_WIDTH:0]   count_q, count_d;
   logic [A_WIDTH:0]   max_count_q, max_count_d;
   logic               empty_q, empty_d;
   logic               full_q, full_d;
   logic               almost_empty_q, almost_empty_d;
   logic               almost_full_q, almost_full_d;
   logic               overflow_q, overflow_d;
   logic               underflow_q, underflow_d;
   logic               wr_ok;
   logic               rd_ok;

   // A write on full is still taken when a read frees a slot in the same cycle.
   assign wr_ok = wr & (~full_q | rd);
   assign rd_ok = rd & ~empty_q;

   // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      max_count_d = max_count_q;
      overflow_d  = overflow_q & ~clr_err;
      underflow_d = underflow_q & ~clr_err;

      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;

      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (wr & full_q & ~rd) overflow_d  = 1'b1;
      if (rd & empty_q)      underflow_d = 1'b1;

      // Clearing restarts the watermark from the level being entered.
      if (clr_err || (count_d > max_count_q)) max_count_d = count_d;

      empty_d        = (count_d == '0);
      full_d         = (count_d == DEPTH_C);
      almost_empty_d = (count_d <= AE_C);
      almost_full_d  = (count_d >= AF_C);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         max_count_q    <= '0;
         empty_q        <= 1'b1;
         full_q         <= 1'b0;
         almost_empty_q <= 1'b1;
         almost_full_q  <= 1'b0;
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         max_count_q    <= max_count_d;
         empty_q        <= empty_d;
         full_q         <= full_d;
         almost_empty_q <= almost_empty_d;
         almost_full_q  <= almost_full_d;
         overflow_q     <= overflow_d;
         underflow_q    <= underflow_d;
      end
   end

   // NOTE: the storage array has no reset; pointers and count alone define which words are valid.
   always_ff @(posedge clk) begin
      if (wr_ok && !rst) mem_q[wr_ptr_q] <= w_data;
   end

   assign r_data       = mem_q[rd_ptr_q];
   assign empty        = empty_q;
   assign full         = full_q;
   assign almost_empty = almost_empty_q;
   assign almost_full  = almost_full_q;
   assign count        = count_q;
   assign max_count    = max_count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule
